// File: rtl/cache_arbiter.sv
// Shares one cache controller between the instruction-fetch and data requesters.
// Latches one request at a time and adds anti-starvation, a completion timeout, error latching and hit/miss counters.
module cache_arbiter #(
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned TIMEOUT    = 64,
    parameter logic [15:0] CNT_MAX    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd,
    input  logic [15:0] i_addr,
    output logic [15:0] i_data,
    output logic        i_done,
    output logic        i_stall,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_din,
    output logic [15:0] d_data,
    output logic        d_done,
    output logic        d_stall,
    output logic        d_err,
    output logic        c_Rd,
    output logic        c_Wr,
    output logic [15:0] c_Addr,
    output logic [15:0] c_DataIn,
    input  logic [15:0] c_DataOut,
    input  logic        c_Done,
    input  logic        c_CacheHit,
    input  logic        c_err,
    output logic        busy,
    output logic        err,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    localparam int unsigned DW = 16;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        ERROR   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rd_stb_q, rd_stb_d;
    logic          wr_stb_q, wr_stb_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [DW-1:0] hit_q, hit_d;
    logic [DW-1:0] miss_q, miss_d;

    logic d_req, d_bad, i_pri, i_win, d_win, in_grant;

    // A conflicting rd+wr is not a data request; the instruction side may still win.
    assign d_bad    = d_rd & d_wr;
    assign d_req    = d_rd ^ d_wr;
    assign i_pri    = i_rd && (starve_q == SW'(STARVE_MAX));
    assign i_win    = i_rd && (i_pri || !d_req);
    assign d_win    = d_req && !i_pri;
    assign in_grant = (state_q == GRANT_I) || (state_q == GRANT_D);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_stb_d = rd_stb_q;
        wr_stb_d = wr_stb_q;
        starve_d = starve_q;
        tmo_d    = tmo_q;
        hit_d    = hit_q;
        miss_d   = miss_q;

        if (c_err) begin
            state_d  = ERROR;
            rd_stb_d = 1'b0;
            wr_stb_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (d_win) begin
                        state_d  = GRANT_D;
                        addr_d   = d_addr;
                        wdata_d  = d_wr ? d_din : '0;
                        rd_stb_d = d_rd;
                        wr_stb_d = d_wr;
                        tmo_d    = '0;
                        starve_d = starve_q + SW'(i_rd);
                    end else if (i_win) begin
                        state_d  = GRANT_I;
                        addr_d   = i_addr;
                        wdata_d  = '0;
                        rd_stb_d = 1'b1;
                        wr_stb_d = 1'b0;
                        tmo_d    = '0;
                        starve_d = '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    // Completion takes precedence over an expiring timeout.
                    if (c_Done) begin
                        state_d  = IDLE;
                        rd_stb_d = 1'b0;
                        wr_stb_d = 1'b0;
                        if (c_CacheHit) begin
                            if (hit_q != CNT_MAX) hit_d = hit_q + DW'(1);
                        end else begin
                            if (miss_q != CNT_MAX) miss_d = miss_q + DW'(1);
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        state_d  = ERROR;
                        rd_stb_d = 1'b0;
                        wr_stb_d = 1'b0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                default: begin
                    rd_stb_d = 1'b0;
                    wr_stb_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            starve_q <= '0;
            tmo_q    <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    // Completion and read data are passed through in the controller's Done cycle.
    assign i_done   = (state_q == GRANT_I) && c_Done && !c_err;
    assign d_done   = (state_q == GRANT_D) && c_Done && !c_err;
    assign i_data   = i_done ? c_DataOut : '0;
    assign d_data   = d_done ? c_DataOut : '0;
    assign i_stall  = i_rd && !i_done;
    assign d_stall  = (d_rd || d_wr) && !d_done;
    assign d_err    = (state_q == IDLE) && d_bad;

    assign c_Rd     = rd_stb_q;
    assign c_Wr     = wr_stb_q;
    assign c_Addr   = addr_q;
    assign c_DataIn = wdata_q;
    assign busy     = in_grant;
    assign err      = (state_q == ERROR);
    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter that shares the single direct-mapped cache controller between the instruction-fetch requester and the data (load/store) requester of the pipelined core. It latches one request at a time, drives the controller's Rd/Wr/Addr/DataIn handshake until the controller signals Done, and routes data and completion back to the winning requester. It also enforces anti-starvation, a completion timeout, illegal-request detection and saturating hit/miss counters.

## Interface
- STARVE_MAX, 3: consecutive data grants allowed while an instruction request waits.
- TIMEOUT, 64: max cycles in a grant state without c_Done before ERROR.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_rd  in  1  instruction read request, held until i_done
- i_addr  in  16  instruction address
- i_data  out  16  read data, valid when i_done
- i_done  out  1  one-cycle completion pulse
- i_stall  out  1  i_rd high and i_done low
- d_rd / d_wr  in  1 each  data read / write request, held until d_done
- d_addr  in  16  data address
- d_din  in  16  write data
- d_data  out  16  read data, valid when d_done
- d_done  out  1  one-cycle completion pulse
- d_stall  out  1  (d_rd|d_wr) high and d_done low
- d_err  out  1  one-cycle pulse when d_rd & d_wr both high
- c_Rd / c_Wr  out  1 each  controller request strobes
- c_Addr  out  16  latched address
- c_DataIn  out  16  latched write data (0 for reads)
- c_DataOut  in  16  controller read data
- c_Done  in  1  controller completion
- c_CacheHit  in  1  hit qualifier, valid with c_Done
- c_err  in  1  controller error
- busy  out  1  high in GRANT_I or GRANT_D
- err  out  1  sticky error, high in ERROR
- hit_cnt / miss_cnt  out  16 each  saturating completion counters

## Operation
- States: IDLE, GRANT_I, GRANT_D, ERROR (2-bit registered state).
- IDLE: evaluate requests; on win, latch addr, data, and op (rd/wr) into registers, go to grant state. No request -> stay IDLE.
- Priority: data beats instruction, except when i_rd pending and starve_cnt == STARVE_MAX -> instruction wins.
- starve_cnt (width clog2(STARVE_MAX+1)): +1 on each data grant made while i_rd high; cleared on instruction grant; never exceeds STARVE_MAX.
- d_rd & d_wr both high in IDLE: pulse d_err, no data grant that cycle; instruction may still be granted.
- GRANT_x: c_Rd (or c_Wr for latched data write) held high every cycle; c_Addr/c_DataIn from latches only. Outputs do not follow requester inputs after latch.
- c_Done in GRANT_x: same cycle pulse x_done, x_data = c_DataOut (comb. pass-through); counter update; next state IDLE.
- hit_cnt += 1 on c_Done & c_CacheHit; miss_cnt += 1 on c_Done & ~c_CacheHit; both hold at 16'hFFFF.
- Timeout counter: cleared on entry to grant, +1 per grant cycle; reaching TIMEOUT without c_Done -> ERROR.
- c_err high in any state -> ERROR. ERROR: all strobes/done low, err=1, stays until rst.

## Timing
- Reset values: state IDLE, all strobes and done pulses 0, c_Addr/c_DataIn 0, latches 0, starve_cnt 0, timeout count 0, hit_cnt/miss_cnt 0, busy 0, err 0, d_err 0.
- Request seen in IDLE cycle N -> c_Rd/c_Wr high from cycle N+1.
- Completion: x_done in the c_Done cycle; IDLE at next edge; earliest next grant strobe two cycles after c_Done (one IDLE cycle gives controller its IDLE cycle).
- Hit read (controller Done one cycle after strobe): request to done = 2 cycles.
- Requester dropping request mid-grant: ignored; transaction completes, done pulse still issued.
- c_Done in IDLE: ignored (no done, no counter change).
- rst mid-grant: immediate return to reset values at the edge; in-flight transaction abandoned.
- c_Done and timeout in same cycle: c_Done wins.

## Test plan
- Reset, then i_rd=1, i_addr=16'h0040, c_Done+c_CacheHit one cycle after c_Rd, c_DataOut=16'hBEEF -> c_Rd at cycle 1, i_done and i_data=16'hBEEF at cycle 2, hit_cnt=1.
- i_rd and d_wr (d_addr=16'h0100, d_din=16'h1234) raised together, both held -> data granted first with c_Wr, c_DataIn=16'h1234; instruction granted after; with d_wr re-asserted continuously, instruction wins after exactly 3 data grants.
- d_rd=d_wr=1 in IDLE -> d_err one-cycle pulse, no c_Rd/c_Wr, state stays IDLE.
- Grant with c_Done never asserted -> err=1 after 64 grant cycles, strobes low, stays ERROR until rst; rst -> all outputs zero.
- Miss path: c_Done with c_CacheHit=0 after 12 stall cycles -> done pulse on that cycle, miss_cnt=1; preset counter to 16'hFFFF via 65535 hits -> stays 16'hFFFF.
- c_err pulse mid-grant -> ERROR next edge, no done pulse issued.
